// File: rtl/dot_matrix_arbiter.sv
// Round-robin display arbiter for two pattern requesters with tick-counted hold and a one-cycle gap.
// Optional: DOT_MATRIX_ARBITER_PREEMPT_EN lets req[1] take the display from requester 0 mid-hold.
module dot_matrix_arbiter #(
  parameter int unsigned HOLD_TICKS = 4,
  parameter logic [1:0]  IDLE_PAT   = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] req,
  input  logic [1:0] pat0,
  input  logic [1:0] pat1,
  output logic [1:0] grant,
  output logic [1:0] done,
  output logic [1:0] pat_sel
);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  localparam logic [3:0] LAST_CNT = 4'(HOLD_TICKS - 1);

  state_t     state, state_n;
  logic [1:0] grant_n, done_n, pat_n;
  logic [3:0] cnt, cnt_n;
  logic       last, last_n;
  logic       owner, pick;

  always_comb begin
    state_n = state;
    grant_n = grant;
    done_n  = '0;
    pat_n   = pat_sel;
    cnt_n   = cnt;
    last_n  = last;
    owner   = grant[1];
    // On a tie, serve whichever requester was not granted last.
    pick    = (req == 2'b11) ? ~last : req[1];
    case (state)
      IDLE: begin
        if (|req) begin
          state_n = SHOW;
          grant_n = pick ? 2'b10 : 2'b01;
          pat_n   = pick ? pat1 : pat0;
          cnt_n   = '0;
          last_n  = pick;
        end
      end
      SHOW: begin
        if (!req[owner]) begin
          state_n = IDLE;
          grant_n = '0;
          pat_n   = IDLE_PAT;
        end
`ifdef DOT_MATRIX_ARBITER_PREEMPT_EN
        else if (!owner && req[1]) begin
          grant_n = 2'b10;
          pat_n   = pat1;
          cnt_n   = '0;
          last_n  = 1'b1;
        end
`endif
        else if (tick) begin
          if (cnt == LAST_CNT) begin
            state_n = GAP;
            grant_n = '0;
            pat_n   = IDLE_PAT;
            done_n  = grant;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant   <= '0;
      done    <= '0;
      pat_sel <= IDLE_PAT;
      cnt     <= '0;
      last    <= 1'b1;
    end else begin
      state   <= state_n;
      grant   <= grant_n;
      done    <= done_n;
      pat_sel <= pat_n;
      cnt     <= cnt_n;
      last    <= last_n;
    end
  end

endmodule

// File: tb/tb_dot_matrix_arbiter.sv
// Directed bench for dot_matrix_arbiter with HOLD_TICKS=4, IDLE_PAT=2'b11.
module tb_dot_matrix_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] req = '0, pat0 = '0, pat1 = '0;
  logic [1:0] grant, done, pat_sel;
  int unsigned n_cmp = 0, n_err = 0;

  dot_matrix_arbiter #(.HOLD_TICKS(4), .IDLE_PAT(2'b11)) dut (
    .clk(clk), .reset(reset), .tick(tick), .req(req), .pat0(pat0), .pat1(pat1),
    .grant(grant), .done(done), .pat_sel(pat_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [1:0] g, input logic [1:0] d, input logic [1:0] p);
    chk({tag, ".grant"}, grant, g);
    chk({tag, ".done"}, done, d);
    chk({tag, ".pat_sel"}, pat_sel, p);
  endtask

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  initial begin
    // reset state
    cyc(0); cyc(0);
    chk3("reset", 2'b00, 2'b00, 2'b11);
    reset = 1'b1;

    // scenario 1 + 4: single requester, ticks every 8 cycles, pat0 changes mid-hold
    req = 2'b01; pat0 = 2'b00;
    cyc(0);
    chk3("s1_grant", 2'b01, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      repeat (7) cyc(0);
      cyc(1);
      if (i == 1) pat0 = 2'b10;
      if (i == 2) chk3("s4_hold", 2'b01, 2'b00, 2'b00);
    end
    chk3("s1_done", 2'b00, 2'b01, 2'b11);
    req = 2'b00;
    cyc(0);
    chk3("s1_idle", 2'b00, 2'b00, 2'b11);

    // scenario 2: tie alternates, starting with requester 0 after reset
    reset = 1'b0; cyc(0); reset = 1'b1;
    req = 2'b11; pat0 = 2'b01; pat1 = 2'b10;
    cyc(0);
    chk3("s2_g0", 2'b01, 2'b00, 2'b01);
    repeat (4) cyc(1);
    chk3("s2_d0", 2'b00, 2'b01, 2'b11);
    cyc(0);
    chk3("s2_gap", 2'b00, 2'b00, 2'b11);
    cyc(0);
    chk3("s2_g1", 2'b10, 2'b00, 2'b10);
    repeat (4) cyc(1);
    chk3("s2_d1", 2'b00, 2'b10, 2'b11);
    cyc(0);
    cyc(0);
    chk3("s2_g2", 2'b01, 2'b00, 2'b01);

    // scenario 3: abort after 2 ticks; last grant is kept
    cyc(1); cyc(1);
    req = 2'b00;
    cyc(0);
    chk3("s3_abort", 2'b00, 2'b00, 2'b11);
    cyc(0);
    chk3("s3_after", 2'b00, 2'b00, 2'b11);
    req = 2'b11;
    cyc(0);
    chk3("s3_rr", 2'b10, 2'b00, 2'b10);

    // abort coincides with final tick: no done
    cyc(1); cyc(1); cyc(1);
    req = 2'b00;
    cyc(1);
    chk3("abort_final", 2'b00, 2'b00, 2'b11);
    cyc(1);
    chk3("idle_tick", 2'b00, 2'b00, 2'b11);

    // scenario 5: asynchronous reset mid-hold
    req = 2'b01;
    cyc(0);
    chk3("s5_grant", 2'b01, 2'b00, 2'b01);
    cyc(1);
    #2 reset = 1'b0;
    #1 chk3("s5_async", 2'b00, 2'b00, 2'b11);
    req = 2'b11;
    cyc(0);
    chk3("s5_held", 2'b00, 2'b00, 2'b11);
    reset = 1'b1;
    cyc(0);
    chk3("s5_restart", 2'b01, 2'b00, 2'b01);

    // scenario 6: req[1] while requester 0 holds
`ifdef DOT_MATRIX_ARBITER_PREEMPT_EN
    cyc(1);
    chk3("s6_preempt", 2'b10, 2'b00, 2'b10);
    cyc(1); cyc(1); cyc(1);
    chk3("s6_hold", 2'b10, 2'b00, 2'b10);
    cyc(1);
    chk3("s6_done", 2'b00, 2'b10, 2'b11);
`else
    cyc(1);
    chk3("s6_nopreempt", 2'b01, 2'b00, 2'b01);
    cyc(1); cyc(1); cyc(1);
    chk3("s6_done0", 2'b00, 2'b01, 2'b11);
    cyc(0);
    cyc(0);
    chk3("s6_grant1", 2'b10, 2'b00, 2'b10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dot_matrix_arbiter.md
DOT_MATRIX_ARBITER -- requirements
Module: dot_matrix_arbiter

Interface
REQ-001 The module SHALL have parameter HOLD_TICKS, default 4, meaning the number of tick pulses a granted pattern is held (legal range 1..15).
REQ-002 The module SHALL have parameter IDLE_PAT, default 2'b11, meaning the pattern select driven when no requester is granted.
REQ-003 The module SHALL have port clk, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The module SHALL have port tick, input, 1 bit: one-cycle frame-time strobe.
REQ-006 The module SHALL have port req, input, 2 bits: per-requester display request, level; req[1] is the high-priority (score/banner) source.
REQ-007 The module SHALL have port pat0, input, 2 bits: pattern select offered by requester 0.
REQ-008 The module SHALL have port pat1, input, 2 bits: pattern select offered by requester 1.
REQ-009 The module SHALL have port grant, output, 2 bits: one-hot owner of the display, 2'b00 when none.
REQ-010 The module SHALL have port done, output, 2 bits: one-cycle pulse to the requester whose hold completed.
REQ-011 The module SHALL have port pat_sel, output, 2 bits: pattern select fed to the display driver's 2-bit pattern input.

Function
REQ-012 The FSM SHALL have states IDLE, SHOW and GAP, with all outputs registered.
REQ-013 IDLE: grant=00, pat_sel=IDLE_PAT; if any req bit is high, the next cycle SHALL be SHOW with grant set.
REQ-014 Arbitration SHALL be round-robin: when both requesters are high, grant the requester other than last_grant; when one is high, grant it.
REQ-015 On entry to SHOW the pattern of the granted requester SHALL be latched into pat_sel at that edge and held regardless of later pat0/pat1 changes; the hold counter SHALL clear to 0.
REQ-016 In SHOW, each cycle with tick=1 SHALL increment the 4-bit hold counter; tick in the IDLE and GAP states SHALL be ignored.
REQ-017 In SHOW, tick=1 with counter==HOLD_TICKS-1 SHALL move to GAP next cycle: grant=00, pat_sel=IDLE_PAT, and done one-hot to the served requester for exactly that one cycle.
REQ-018 GAP SHALL last exactly one cycle and then go to IDLE, so grants are separated by at least two cycles.
REQ-019 In SHOW, a low req bit of the granted requester SHALL abort: the next cycle is IDLE, grant=00, pat_sel=IDLE_PAT, and no done pulse.
REQ-020 When abort and the final tick coincide, abort SHALL win and no done pulse is issued.
REQ-021 last_grant SHALL update on every grant and SHALL NOT change on abort.
REQ-022 grant SHALL never have both bits set, and done SHALL never be high while grant is nonzero.

Reset
REQ-023 While reset=0, all state SHALL be cleared asynchronously: state=IDLE, grant=00, done=00, pat_sel=IDLE_PAT, counter=0, last_grant=1 so that requester 0 wins the first tie.
REQ-024 Reset asserted mid-SHOW SHALL discard the hold without a done pulse; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-025 With macro DOT_MATRIX_ARBITER_PREEMPT_EN defined, req[1]=1 while grant=01 in SHOW SHALL switch the owner at the next edge to grant=10 with pat1 latched, counter=0 and last_grant=1, and SHALL issue no done to requester 0.
REQ-026 Without DOT_MATRIX_ARBITER_PREEMPT_EN, SHOW SHALL be non-preemptive, and req[1] SHALL wait for GAP and IDLE.

Verification (HOLD_TICKS=4, IDLE_PAT=11)
REQ-027 Scenario 1: reset release, req=01, pat0=00, tick every 8 cycles -> grant=01 and pat_sel=00 one cycle after req; done=01 one cycle after the 4th tick; then pat_sel=11.
REQ-028 Scenario 2: req=11 held from IDLE after reset -> grants alternate 01,10,01 with pat_sel=pat0,pat1,pat0, and each grant is separated by a 2-cycle GAP and IDLE.
REQ-029 Scenario 3: req0 dropped after 2 ticks of SHOW -> grant=00, pat_sel=11 next cycle, done stays 00.
REQ-030 Scenario 4: pat0 changed 00->10 mid-SHOW -> pat_sel stays 00 until GAP.
REQ-031 Scenario 5: reset pulsed low mid-SHOW -> grant=00, done=00, pat_sel=11 immediately (asynchronous); after release, req=11 grants 01 first.
REQ-032 Scenario 6: PREEMPT_EN defined, grant=01, req[1] rises -> grant=10, pat_sel=pat1 next cycle, done=10 after 4 further ticks; without the macro, grant=10 follows done=01 plus GAP.
